// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch resolution, predictor update and mispredict redirect.
// Ports:
//   cpu_clk, cpu_rst                           clock and synchronous active-high reset
//   br_valid_ex, br_funct3_ex                  conditional branch in EX and its compare type
//   br_pc_ex, br_imm_ex                        branch PC and sign-extended offset
//   src_data1_ex, src_data2_ex                 forwarded operands
//   pred_taken_ex, pred_target_ex              prediction carried with the branch
//   redirect_valid, redirect_pc, redirect_ready  held redirect request to fetch
//   ex_stall                                   EX frozen while a redirect is pending
//   branch_ex, branch_pc_ex, branch_target_pc, branch_taken_ex  one-cycle predictor update
//   branch_cnt, mispredict_cnt                 event counters
module branch_resolve #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  br_valid_ex,
    input  logic [2:0]            br_funct3_ex,
    input  logic [ADDR_WIDTH-1:0] br_pc_ex,
    input  logic [ADDR_WIDTH-1:0] br_imm_ex,
    input  logic [DATA_WIDTH-1:0] src_data1_ex,
    input  logic [DATA_WIDTH-1:0] src_data2_ex,
    input  logic                  pred_taken_ex,
    input  logic [ADDR_WIDTH-1:0] pred_target_ex,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  redirect_ready,
    output logic                  ex_stall,
    output logic                  branch_ex,
    output logic [ADDR_WIDTH-1:0] branch_pc_ex,
    output logic [ADDR_WIDTH-1:0] branch_target_pc,
    output logic                  branch_taken_ex,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt
);
    typedef enum logic {IDLE, REDIRECT} state_e;
    state_e state_q, state_d;
    logic                  legal, eq, lt, ltu, taken, accept, mispredict;
    logic [ADDR_WIDTH-1:0] target, fallthrough, actual_next, pred_next;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, branch_pc_q, branch_target_q;
    logic                  branch_ex_q, branch_taken_q;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, mispredict_cnt_q;

    // funct3 010/011 are not branches; funct3[0] inverts the base compare
    assign legal       = br_funct3_ex[2:1] != 2'b01;
    assign eq          = src_data1_ex == src_data2_ex;
    assign lt          = $signed(src_data1_ex) < $signed(src_data2_ex);
    assign ltu         = src_data1_ex < src_data2_ex;
    assign taken       = (br_funct3_ex[2] ? (br_funct3_ex[1] ? ltu : lt) : eq) ^ br_funct3_ex[0];
    assign target      = br_pc_ex + br_imm_ex;
    assign fallthrough = br_pc_ex + ADDR_WIDTH'(4);
    assign actual_next = taken ? target : fallthrough;
    assign pred_next   = pred_taken_ex ? pred_target_ex : fallthrough;
    assign mispredict  = actual_next != pred_next;
    assign accept      = br_valid_ex && state_q == IDLE && legal;

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = (accept && mispredict) ? REDIRECT : IDLE;
        else
            state_d = redirect_ready ? IDLE : REDIRECT;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q          <= IDLE;
            redirect_pc_q    <= '0;
            branch_ex_q      <= 1'b0;
            branch_pc_q      <= '0;
            branch_target_q  <= '0;
            branch_taken_q   <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            branch_ex_q <= accept;
            if (accept) begin
                branch_pc_q     <= br_pc_ex;
                branch_target_q <= target;
                branch_taken_q  <= taken;
                branch_cnt_q    <= branch_cnt_q + CNT_WIDTH'(1);
            end
            if (accept && mispredict) begin
                redirect_pc_q    <= actual_next;
                mispredict_cnt_q <= mispredict_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign redirect_valid   = state_q == REDIRECT;
    assign ex_stall         = state_q == REDIRECT;
    assign redirect_pc      = redirect_pc_q;
    assign branch_ex        = branch_ex_q;
    assign branch_pc_ex     = branch_pc_q;
    assign branch_target_pc = branch_target_q;
    assign branch_taken_ex  = branch_taken_q;
    assign branch_cnt       = branch_cnt_q;
    assign mispredict_cnt   = mispredict_cnt_q;
endmodule
